// File: rtl/hp_filter.sv
// hp_filter: Pan-Tompkins high-pass stage, y(n) = x(n-16) - floor(sum of last 32 samples / 32).
// Ports:
//   clk       sample-domain clock, rising edge
//   rstn      asynchronous active-low reset; clears all history
//   en        sample strobe; data consumed on each rising edge with en=1
//   data      signed input sample x(n) (IN_WIDTH)
//   out       signed filtered sample y(n), registered (OUT_WIDTH)
//   out_valid one-cycle pulse when out was updated
//   primed    sticky, high once 32 samples have been accepted
// Optional: define HP_FILTER_SATURATE_EN to clamp the output instead of wrapping it.
module hp_filter #(
    parameter int IN_WIDTH  = 11,
    parameter int OUT_WIDTH = 11,
    parameter int ACC_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        en,
    input  logic signed [IN_WIDTH-1:0]  data,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        out_valid,
    output logic                        primed
);
    logic signed [IN_WIDTH-1:0]  dly [32];
    logic [4:0]                  wptr;
    logic [4:0]                  rptr;
    logic [5:0]                  cnt;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] sum_next;
    logic signed [IN_WIDTH-1:0]  mean;
    logic signed [OUT_WIDTH-1:0] out_next;

    // 5-bit add wraps the mid-window tap naturally
    assign rptr     = wptr + 5'd16;
    assign sum_next = sum + ACC_WIDTH'(data) - ACC_WIDTH'(dly[wptr]);
    // A 32-sample window always fits in IN_WIDTH+5 bits, so the mean fits in IN_WIDTH
    assign mean     = sum_next[IN_WIDTH+4:5];

`ifdef HP_FILTER_SATURATE_EN
    localparam int DW = OUT_WIDTH + 2;
    localparam logic signed [DW-1:0] MAXV = {3'b000, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [DW-1:0] MINV = {3'b111, {(OUT_WIDTH-1){1'b0}}};
    logic signed [DW-1:0] diff;
    assign diff     = DW'(dly[rptr]) - DW'(mean);
    assign out_next = diff > MAXV ? MAXV[OUT_WIDTH-1:0] :
                      diff < MINV ? MINV[OUT_WIDTH-1:0] : diff[OUT_WIDTH-1:0];
`else
    // Subtracting at OUT_WIDTH is the exact difference modulo 2^OUT_WIDTH
    assign out_next = OUT_WIDTH'(dly[rptr]) - OUT_WIDTH'(mean);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) dly[i] <= '0;
            sum       <= '0;
            wptr      <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= en;
            if (en) begin
                dly[wptr] <= data;
                wptr      <= wptr + 5'd1;
                sum       <= sum_next;
                out       <= out_next;
                if (!cnt[5]) cnt <= cnt + 6'd1;
            end
        end
    end

    assign primed = cnt[5];
endmodule

// File: tb/tb_hp_filter.sv
// tb_hp_filter: table-driven and randomized checks of hp_filter against spec values and a windowed-average model.
module tb_hp_filter;
    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               en = 1'b0;
    logic signed [10:0] data = '0;
    logic signed [10:0] out;
    logic               out_valid;
    logic               primed;

    int n_checks = 0;
    int n_fail = 0;
    int hist[$];

    typedef struct {
        bit en;
        int data;
        int out;
        bit valid;
        bit primed;
    } vec_t;

    vec_t imp[40];

    hp_filter dut (
        .clk(clk), .rstn(rstn), .en(en), .data(data),
        .out(out), .out_valid(out_valid), .primed(primed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic cyc(input bit e, input int d);
        @(negedge clk);
        en = e;
        data = 11'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        hist.delete();
    endtask

    function automatic int narrow(input int d);
`ifdef HP_FILTER_SATURATE_EN
        return d > 1023 ? 1023 : d < -1024 ? -1024 : d;
`else
        return ((d + 1024) % 2048 + 2048) % 2048 - 1024;
`endif
    endfunction

    // Reference: mean of the last 32 accepted samples (zeros before reset history), floored
    function automatic int model_out();
        int n = hist.size();
        int s = 0;
        int mean;
        int x16;
        for (int k = 0; k < 32; k++) if (n - 1 - k >= 0) s += hist[n-1-k];
        mean = (s >= 0) ? s / 32 : -((-s + 31) / 32);
        x16 = (n - 17 >= 0) ? hist[n-17] : 0;
        return narrow(x16 - mean);
    endfunction

    task automatic run_impulse(input string name);
        for (int i = 0; i < 40; i++) begin
            cyc(imp[i].en, imp[i].data);
            chk({name, "_out"}, i, int'(out), imp[i].out);
            chk({name, "_valid"}, i, int'(out_valid), int'(imp[i].valid));
            chk({name, "_primed"}, i, int'(primed), int'(imp[i].primed));
        end
    endtask

    initial begin
        int exp;
        int guard;
        for (int i = 0; i < 40; i++) begin
            imp[i].en = 1'b1;
            imp[i].data = (i == 0) ? 320 : 0;
            imp[i].out = (i == 16) ? 310 : (i < 32) ? -10 : 0;
            imp[i].valid = 1'b1;
            imp[i].primed = (i >= 31);
        end

        #1;
        chk("rst_out", 0, int'(out), 0);
        chk("rst_valid", 0, int'(out_valid), 0);
        chk("rst_primed", 0, int'(primed), 0);
        @(negedge clk);
        rstn = 1'b1;

        run_impulse("imp1");

        // Asynchronous reset mid-stream, observed before any clock edge
        for (int i = 0; i < 5; i++) cyc(1'b1, 200 + i);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_out", 0, int'(out), 0);
        chk("async_valid", 0, int'(out_valid), 0);
        chk("async_primed", 0, int'(primed), 0);
        @(negedge clk);
        rstn = 1'b1;
        en = 1'b0;
        run_impulse("imp2");

        // Strobe gaps: 1,0,0 pattern
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, imp[i].data);
            chk("gap_out", i, int'(out), imp[i].out);
            chk("gap_valid", i, int'(out_valid), 1);
            for (int j = 0; j < 2; j++) begin
                cyc(1'b0, 555);
                chk("gap_hold", i, int'(out), imp[i].out);
                chk("gap_idle_valid", i, int'(out_valid), 0);
            end
        end

        // DC rejection
        do_reset();
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 100);
            exp = (k < 16) ? -((100 * (k + 1)) / 32) :
                  (k < 32) ? 100 - (100 * (k + 1)) / 32 : 0;
            chk("dc_out", k, int'(out), exp);
        end

        // Overflow at the 48th strobe
        do_reset();
        for (int k = 0; k < 48; k++) cyc(1'b1, (k < 32) ? 1023 : -1024);
`ifdef HP_FILTER_SATURATE_EN
        chk("ovf_out", 47, int'(out), 1023);
`else
        chk("ovf_out", 47, int'(out), -1024);
`endif

        // Random samples with random gaps, covering pointer wrap
        do_reset();
        exp = 0;
        guard = 0;
        while (hist.size() < 100 && guard < 1000) begin
            bit e;
            int d;
            guard++;
            e = ($urandom_range(0, 3) != 0);
            d = int'($urandom_range(0, 2047)) - 1024;
            cyc(e, d);
            if (e) begin
                hist.push_back(d);
                exp = model_out();
            end
            chk("rnd_out", hist.size(), int'(out), exp);
            chk("rnd_valid", hist.size(), int'(out_valid), int'(e));
            chk("rnd_primed", hist.size(), int'(primed), int'(hist.size() >= 32));
        end
        chk("rnd_count", 0, hist.size(), 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
